// File: rtl/seg7_bcd_encoder.sv
// seg7_bcd_encoder: debounces a 7-segment pattern, decodes it to BCD and hands it off via valid/ready.
module seg7_bcd_encoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  out_bcd,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic [15:0] history
);
    typedef enum logic [1:0] {IDLE, FILTER, PRESENT, WAIT} state_t;
    state_t state, state_nxt;
    logic [6:0] seg_q, cap;
    logic [3:0] cnt, cnt_nxt, dig;
    logic legal, load, hold, stable, acc_dig, acc_err, hs;
    always_comb begin
        legal = 1'b1;
        dig = 4'd0;
        case (seg_q)
            7'b0111111: dig = 4'd0;
            7'b0000110: dig = 4'd1;
            7'b1011011: dig = 4'd2;
            7'b1001111: dig = 4'd3;
            7'b1100110: dig = 4'd4;
            7'b1101101: dig = 4'd5;
            7'b1111101: dig = 4'd6;
            7'b0000111: dig = 4'd7;
            7'b1111111: dig = 4'd8;
            7'b1101111: dig = 4'd9;
            default:    legal = 1'b0;
        endcase
    end
    // The count produced this cycle is what gets compared, so a fresh capture with
    // STABLE_CYCLES=1 is accepted immediately.
    assign load    = seg_q != 7'd0 && (state == IDLE || (state != PRESENT && seg_q != cap));
    assign hold    = state == FILTER && seg_q == cap;
    assign cnt_nxt = load ? 4'd1 : hold ? cnt + 4'd1 : cnt;
    assign stable  = (load || hold) && cnt_nxt == 4'(STABLE_CYCLES);
    assign acc_dig = stable && legal;
    assign acc_err = stable && !legal;
    assign hs      = state == PRESENT && out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == PRESENT ? (hs ? WAIT : PRESENT) :
                    seg_q == 7'd0    ? IDLE :
                    acc_dig          ? PRESENT :
                    acc_err          ? WAIT :
                    (load || hold)   ? FILTER : state;
    end
    always_comb begin
        out_valid = state == PRESENT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q   <= 7'd0;
            cap     <= 7'd0;
            cnt     <= 4'd0;
            out_bcd <= 4'd0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
            history <= 16'd0;
        end else begin
            seg_q <= seg_in;
            cnt   <= cnt_nxt;
            err   <= acc_err;
            if (load) cap <= seg_q;
            if (acc_dig) out_bcd <= dig;
            if (acc_err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
            if (hs) history <= {history[11:0], out_bcd};
        end
    end
endmodule

// File: tb/tb_seg7_bcd_encoder.sv
// tb_seg7_bcd_encoder: directed and random stimulus compared each cycle against a run-length reference model.
module tb_seg7_bcd_encoder;
    localparam int S = 4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = 7'd0;
    logic        out_ready = 1'b0;
    logic        out_valid, err;
    logic [3:0]  out_bcd;
    logic [7:0]  err_cnt;
    logic [15:0] history;
    int n_checks = 0;
    int n_errors = 0;
    logic [6:0] codes [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
    logic [6:0]  m_segq, m_blocked, m_run;
    logic        m_pres, m_err;
    logic [3:0]  m_bcd;
    logic [15:0] m_hist;
    int          m_errcnt, m_len;

    seg7_bcd_encoder #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .out_ready(out_ready),
        .out_valid(out_valid), .out_bcd(out_bcd), .err(err), .err_cnt(err_cnt), .history(history)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int digit_of(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (codes[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_segq = 0; m_blocked = 0; m_run = 0; m_pres = 0; m_err = 0;
        m_bcd = 0; m_hist = 0; m_errcnt = 0; m_len = 0;
    endtask

    // A pattern is accepted once it has been seen for S consecutive registered cycles;
    // after acceptance that same pattern is ignored until something else appears.
    task automatic model_edge(input logic [6:0] v, input logic rdy);
        int d;
        m_err = 0;
        if (m_pres) begin
            if (rdy) begin
                m_hist = {m_hist[11:0], m_bcd};
                m_pres = 0;
            end
        end else if (v == 0) begin
            m_len = 0;
            m_blocked = 0;
        end else if (v != m_blocked) begin
            if (v == m_run && m_len > 0) m_len++;
            else begin
                m_run = v; m_len = 1; m_blocked = 0;
            end
            if (m_len == S) begin
                d = digit_of(v);
                if (d >= 0) begin
                    m_pres = 1;
                    m_bcd = 4'(d);
                end else begin
                    m_err = 1;
                    if (m_errcnt < 255) m_errcnt++;
                end
                m_blocked = v;
                m_len = 0;
            end
        end
    endtask

    task automatic step(input logic [6:0] s, input logic r);
        seg_in = s;
        out_ready = r;
        @(posedge clk);
        model_edge(m_segq, r);
        m_segq = s;
        @(negedge clk);
        check("valid", 16'(out_valid), 16'(m_pres));
        check("bcd", 16'(out_bcd), 16'(m_bcd));
        check("err", 16'(err), 16'(m_err));
        check("err_cnt", 16'(err_cnt), 16'(m_errcnt));
        check("history", history, m_hist);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 16'(out_valid), 16'd0);
        check("rst_bcd", 16'(out_bcd), 16'd0);
        check("rst_err", 16'(err), 16'd0);
        check("rst_err_cnt", 16'(err_cnt), 16'd0);
        check("rst_history", history, 16'd0);
        model_reset();
        seg_in = 7'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int nv, ne, hold_n;
        logic [6:0] pat;
        model_reset();
        @(negedge clk);
        pulse_reset();
        for (int k = 1; k <= 7; k++) begin
            step(codes[2], 1'b1);
            check("held2_valid", 16'(out_valid), 16'(k == 5));
            if (k == 5) check("held2_bcd", 16'(out_bcd), 16'd2);
        end
        check("held2_history", history, 16'h0002);
        pulse_reset();
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            step(7'b0000110, 1'b1); nv += int'(out_valid);
            step(7'b0000110, 1'b1); nv += int'(out_valid);
            step(7'b0000111, 1'b1); nv += int'(out_valid);
            step(7'b0000111, 1'b1); nv += int'(out_valid);
        end
        check("toggle_quiet", 16'(nv), 16'd0);
        for (int i = 0; i < 10; i++) begin
            step(7'b0000111, 1'b1);
            nv += int'(out_valid);
        end
        check("toggle_one_valid", 16'(nv), 16'd1);
        check("toggle_history", history, 16'h0007);
        pulse_reset();
        nv = 0; ne = 0;
        for (int i = 0; i < 10; i++) begin
            step(7'b1111100, 1'b1);
            nv += int'(out_valid);
            ne += int'(err);
        end
        check("nondigit_err_pulses", 16'(ne), 16'd1);
        check("nondigit_valid", 16'(nv), 16'd0);
        check("nondigit_err_cnt", 16'(err_cnt), 16'd1);
        pulse_reset();
        for (int i = 0; i < 6; i++) step(codes[9], 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(codes[3], 1'b0);
            check("stall_valid", 16'(out_valid), 16'd1);
            check("stall_bcd", 16'(out_bcd), 16'd9);
        end
        for (int i = 0; i < 12; i++) step(codes[3], 1'b1);
        check("stall_history", history, 16'h0093);
        pulse_reset();
        for (int d = 1; d <= 5; d++) begin
            for (int i = 0; i < 7; i++) step(codes[d], 1'b1);
            step(7'd0, 1'b1);
            step(7'd0, 1'b1);
        end
        check("seq_history", history, 16'h2345);
        for (int i = 0; i < 6; i++) step(codes[5], 1'b0);
        check("pres_before_rst", 16'(out_valid), 16'd1);
        pulse_reset();
        for (int i = 0; i < 8; i++) step(7'd0, 1'b1);
        check("discarded_history", history, 16'd0);
        pulse_reset();
        for (int i = 0; i < 260; i++)
            for (int j = 0; j < 5; j++) step(i % 2 ? 7'h7c : 7'h01, 1'b1);
        check("err_cnt_sat", 16'(err_cnt), 16'd255);
        pulse_reset();
        for (int n = 0; n < 400; n++) begin
            ne = $urandom_range(0, 9);
            pat = ne < 4 ? codes[$urandom_range(0, 9)] : ne < 6 ? 7'd0 : 7'($urandom_range(1, 127));
            hold_n = $urandom_range(1, 8);
            for (int i = 0; i < hold_n; i++) step(pat, $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 49) == 0) pulse_reset();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
